key_event_decoder: RTL

Classifies the debounced key level into discrete user events: short press, double click, long press, and auto-repeat while held. It sits directly downstream of the key debounce stage and consumes its stable, active-low key level. Its single-cycle event pulses drive tracker control logic, such as mode select and threshold step up or down.

---
 rtl/key_event_if.sv | 30 +++
 rtl/key_event_decoder.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/key_event_if.sv
// Key event decoder bus: debounced key level and enable in, held level and event pulses out.
interface key_event_if;
  logic key_db;
  logic enable;
  logic held;
  logic short_pulse;
  logic double_pulse;
  logic long_pulse;
  logic repeat_pulse;

  modport master (
    output key_db,
    output enable,
    input  held,
    input  short_pulse,
    input  double_pulse,
    input  long_pulse,
    input  repeat_pulse
  );

  modport slave (
    input  key_db,
    input  enable,
    output held,
    output short_pulse,
    output double_pulse,
    output long_pulse,
    output repeat_pulse
  );
endinterface

// File: rtl/key_event_decoder.sv
// Classifies the debounced active-low key level into short, double, long and
// auto-repeat single-cycle event pulses plus a registered "held" level.
module key_event_decoder #(
  parameter int unsigned LONG_CNT   = 32'd50000000,
  parameter int unsigned DBL_CNT    = 32'd12500000,
  parameter int unsigned REPEAT_CNT = 32'd5000000
) (
  input logic        clk,
  input logic        rst_n,
  key_event_if.slave bus
);

  localparam int unsigned CNT_W = 32;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    PRESS1    = 3'd1,
    WAIT2     = 3'd2,
    PRESS2    = 3'd3,
    LONG_HOLD = 3'd4
  } state_t;

  logic             r_k0;
  logic             r_k1;
  logic             w_fall;
  logic             w_rise;
  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic             w_cnt_clr;
  logic             w_repeat_tick;

  logic w_held;
  logic w_short;
  logic w_double;
  logic w_long;
  logic w_repeat;
  logic r_held;
  logic r_short;
  logic r_double;
  logic r_long;
  logic r_repeat;

  // Two-stage key sampler; k1 resets high so a key held through reset reads as a press.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_k0 <= 1'b1;
      r_k1 <= 1'b1;
    end else begin
      r_k0 <= bus.key_db;
      r_k1 <= r_k0;
    end
  end

  assign w_fall = r_k1 & ~r_k0;
  assign w_rise = ~r_k1 & r_k0;

  // State register and phase counter.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_clr ? '0 : r_cnt + CNT_W'(1);
    end
  end

  // Next-state logic; an edge always takes priority over a timeout.
  always_comb begin
    w_state_nxt   = r_state;
    w_repeat_tick = 1'b0;
    if (!bus.enable) begin
      w_state_nxt = IDLE;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (w_fall) w_state_nxt = PRESS1;
        end
        PRESS1: begin
          if (w_rise)                                 w_state_nxt = WAIT2;
          else if (r_cnt == CNT_W'(LONG_CNT - 32'd1)) w_state_nxt = LONG_HOLD;
        end
        LONG_HOLD: begin
          if (w_rise)                                   w_state_nxt = IDLE;
          else if (r_cnt == CNT_W'(REPEAT_CNT - 32'd1)) w_repeat_tick = 1'b1;
        end
        WAIT2: begin
          if (w_fall)                                w_state_nxt = PRESS2;
          else if (r_cnt == CNT_W'(DBL_CNT - 32'd1)) w_state_nxt = IDLE;
        end
        PRESS2: begin
          if (w_rise) w_state_nxt = IDLE;
        end
        default: w_state_nxt = IDLE;
      endcase
    end
    // IDLE pins the counter at zero so it can never run long enough to wrap.
    w_cnt_clr = (w_state_nxt != r_state) || w_repeat_tick || (w_state_nxt == IDLE);
  end

  // Output decode from the transition being taken this cycle.
  always_comb begin
    w_short  = 1'b0;
    w_double = 1'b0;
    w_long   = 1'b0;
    w_repeat = 1'b0;
    w_held   = 1'b0;
    if (bus.enable) begin
      w_short  = (r_state == WAIT2)  && (w_state_nxt == IDLE);
      w_double = (r_state == PRESS2) && (w_state_nxt == IDLE);
      w_long   = (r_state == PRESS1) && (w_state_nxt == LONG_HOLD);
      w_repeat = w_repeat_tick;
      w_held   = (w_state_nxt == PRESS1) || (w_state_nxt == PRESS2) ||
                 (w_state_nxt == LONG_HOLD);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_held   <= 1'b0;
      r_short  <= 1'b0;
      r_double <= 1'b0;
      r_long   <= 1'b0;
      r_repeat <= 1'b0;
    end else begin
      r_held   <= w_held;
      r_short  <= w_short;
      r_double <= w_double;
      r_long   <= w_long;
      r_repeat <= w_repeat;
    end
  end

  assign bus.held         = r_held;
  assign bus.short_pulse  = r_short;
  assign bus.double_pulse = r_double;
  assign bus.long_pulse   = r_long;
  assign bus.repeat_pulse = r_repeat;

endmodule
